// File: rtl/pid_loop_sequencer_if.sv
// rtl/pid_loop_sequencer_if.sv - link between the loop sequencer and the pid datapath
interface pid_loop_sequencer_if;
   logic [3:0]         sensors;
   logic               pid_rst;
   logic signed [12:0] pid_output;

   modport master (output sensors, output pid_rst, input pid_output);
   modport slave  (input sensors, input pid_rst, output pid_output);
endinterface

// File: rtl/pid_loop_sequencer.sv
// rtl/pid_loop_sequencer.sv - fixed-rate sample/settle/apply sequencer around pid
// Optional search-mode duties on line loss are enabled by PID_SEQ_SEARCH_EN.
module pid_loop_sequencer #(
   parameter int TICK_DIV   = 100000,
   parameter int PID_LAT    = 4,
   parameter int CORR_SHIFT = 5,
   parameter int BASE_DUTY  = 64,
   parameter int MAX_DUTY   = 127,
   parameter int LOST_LIMIT = 50
`ifdef PID_SEQ_SEARCH_EN
   , parameter int SEARCH_DUTY = 48
`endif
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   input  logic [3:0]                  sensors_raw,
   pid_loop_sequencer_if.master        pid,
   output logic [6:0]                  duty_left,
   output logic [6:0]                  duty_right,
   output logic                        update,
   output logic                        lost,
   output logic [2:0]                  state
);
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RUN     = 3'd1,
      SETTLE  = 3'd2,
      APPLY   = 3'd3,
      STOPPED = 3'd4
   } state_t;

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SET_W = (PID_LAT > 1) ? $clog2(PID_LAT) : 1;
   localparam int LC_W  = $clog2(LOST_LIMIT + 1);

   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [SET_W-1:0]  SET_LAST = SET_W'(PID_LAT - 1);
   localparam logic [LC_W-1:0]   LC_LIMIT = LC_W'(LOST_LIMIT);
   localparam logic signed [9:0] BASE_S   = 10'(BASE_DUTY);
   localparam logic signed [9:0] MAX_S    = 10'(MAX_DUTY);
   localparam logic [6:0]        MAX_D    = 7'(MAX_DUTY);
`ifdef PID_SEQ_SEARCH_EN
   localparam logic [6:0]        SEARCH_D = 7'(SEARCH_DUTY);
`endif

   state_t             st;
   logic [CNT_W-1:0]   period_cnt;
   logic [SET_W-1:0]   settle_cnt;
   logic [LC_W-1:0]    lost_cnt;
   logic [LC_W-1:0]    lost_cnt_inc;
   logic               wrap;
   logic               sample_valid;
   logic signed [12:0] shifted;
   logic signed [7:0]  corr;
   logic signed [9:0]  left_sum;
   logic signed [9:0]  right_sum;
`ifdef PID_SEQ_SEARCH_EN
   logic               last_corr_neg;
`endif

   function automatic logic is_valid(input logic [3:0] s);
      case (s)
         4'b1001, 4'b0111, 4'b0011, 4'b1110, 4'b1100,
         4'b1011, 4'b1101, 4'b0001, 4'b1000: is_valid = 1'b1;
         default:                            is_valid = 1'b0;
      endcase
   endfunction

   function automatic logic [6:0] sat(input logic signed [9:0] v);
      if (v[9])
         sat = 7'd0;
      else if (v > MAX_S)
         sat = MAX_D;
      else
         sat = v[6:0];
   endfunction

   assign shifted      = pid.pid_output >>> CORR_SHIFT;
   assign corr         = 8'(shifted);
   assign left_sum     = BASE_S + {{2{corr[7]}}, corr};
   assign right_sum    = BASE_S - {{2{corr[7]}}, corr};
   assign wrap         = (period_cnt == CNT_LAST);
   assign sample_valid = is_valid(sensors_raw);
   assign lost_cnt_inc = (lost_cnt == LC_LIMIT) ? lost_cnt : lost_cnt + LC_W'(1);
   assign state        = st;

   // Disable behaves like a soft reset but keeps the last sensor snapshot.
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         st          <= IDLE;
         period_cnt  <= '0;
         settle_cnt  <= '0;
         lost_cnt    <= '0;
         pid.pid_rst <= 1'b1;
         duty_left   <= 7'd0;
         duty_right  <= 7'd0;
         update      <= 1'b0;
         lost        <= 1'b0;
         if (rst) begin
            pid.sensors   <= 4'b1001;
`ifdef PID_SEQ_SEARCH_EN
            last_corr_neg <= 1'b0;
`endif
         end
      end else begin
         update <= 1'b0;
         if (st != IDLE)
            period_cnt <= wrap ? '0 : period_cnt + CNT_W'(1);

         case (st)
            IDLE: begin
               st          <= RUN;
               pid.pid_rst <= 1'b0;
            end
            SETTLE: begin
               if (settle_cnt == SET_LAST) begin
                  st         <= APPLY;
                  settle_cnt <= '0;
               end else begin
                  settle_cnt <= settle_cnt + SET_W'(1);
               end
            end
            APPLY: begin
               duty_left     <= sat(left_sum);
               duty_right    <= sat(right_sum);
               update        <= 1'b1;
               st            <= RUN;
`ifdef PID_SEQ_SEARCH_EN
               last_corr_neg <= corr[7];
`endif
            end
            RUN, STOPPED: begin
               // pid_rst is only pulsed on the transition into STOPPED
               if (st == STOPPED)
                  pid.pid_rst <= 1'b0;
               if (wrap) begin
                  pid.sensors <= sensors_raw;
                  if (sample_valid) begin
                     lost_cnt   <= '0;
                     lost       <= 1'b0;
                     settle_cnt <= '0;
                     st         <= SETTLE;
                  end else begin
                     lost     <= 1'b1;
                     lost_cnt <= lost_cnt_inc;
                     if (lost_cnt_inc == LC_LIMIT) begin
                        if (st == RUN) begin
                           st          <= STOPPED;
                           pid.pid_rst <= 1'b1;
                           duty_left   <= 7'd0;
                           duty_right  <= 7'd0;
                        end
                     end
`ifdef PID_SEQ_SEARCH_EN
                     else begin
                        // turn towards the side the line was last seen on
                        update <= 1'b1;
                        if (last_corr_neg) begin
                           duty_left  <= 7'd0;
                           duty_right <= SEARCH_D;
                        end else begin
                           duty_left  <= SEARCH_D;
                           duty_right <= 7'd0;
                        end
                     end
`endif
                  end
               end
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pid_loop_sequencer.sv
// tb/tb_pid_loop_sequencer.sv - directed table-driven bench for pid_loop_sequencer
`timescale 1ns/1ps
module tb_pid_loop_sequencer;
   localparam int TICK_DIV   = 16;
   localparam int PID_LAT    = 4;
   localparam int LOST_LIMIT = 3;
   localparam int FIRST_LAT  = 1 + TICK_DIV + PID_LAT + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [3:0] sensors_raw;
   logic [6:0] duty_left;
   logic [6:0] duty_right;
   logic       update;
   logic       lost;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int pid;
      int left;
      int right;
   } vec_t;
   vec_t vecs[10];

   pid_loop_sequencer_if pif();

   pid_loop_sequencer #(
      .TICK_DIV(TICK_DIV), .PID_LAT(PID_LAT), .CORR_SHIFT(5),
      .BASE_DUTY(64), .MAX_DUTY(127), .LOST_LIMIT(LOST_LIMIT)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .sensors_raw(sensors_raw),
      .pid(pif), .duty_left(duty_left), .duty_right(duty_right),
      .update(update), .lost(lost), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_update(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!update && n < 64);
      chk("update_seen", int'(update), 1);
   endtask

   task automatic watch_quiet(input string name, input int n);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (update) seen++;
      end
      chk(name, seen, 0);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_sensors"}, int'(pif.sensors), 4'b1001);
      chk({tag, "_pid_rst"}, int'(pif.pid_rst), 1);
      chk({tag, "_left"},    int'(duty_left),   0);
      chk({tag, "_right"},   int'(duty_right),  0);
      chk({tag, "_update"},  int'(update),      0);
      chk({tag, "_lost"},    int'(lost),        0);
      chk({tag, "_state"},   int'(state),       0);
   endtask

   initial begin
      int n;
      int lc;
      int exp_state;
      int exp_l;
      int exp_r;
      logic [15:0] valid_mask;
      logic        v;

      vecs[0] = '{0,     64,  64};
      vecs[1] = '{320,   74,  54};
      vecs[2] = '{-320,  54,  74};
      vecs[3] = '{4095,  127, 0};
      vecs[4] = '{-4096, 0,   127};
      vecs[5] = '{-1,    63,  65};
      vecs[6] = '{31,    64,  64};
      vecs[7] = '{2047,  127, 1};
      vecs[8] = '{-2048, 0,   127};
      vecs[9] = '{64,    66,  62};
      valid_mask = 16'h7B8A;

      rst = 1'b1;
      enable = 1'b1;
      sensors_raw = 4'b1001;
      pif.pid_output = 13'sd0;
      step(3);
      chk_reset_values("reset");

      // nominal loop: latency to first update, then one update per period
      for (int i = 0; i < 10; i++) begin
         pif.pid_output = 13'(vecs[i].pid);
         if (i == 0) rst = 1'b0;
         wait_update(n);
         chk($sformatf("vec%0d_latency", i), n, (i == 0) ? FIRST_LAT : TICK_DIV);
         chk($sformatf("vec%0d_left", i),  int'(duty_left),  vecs[i].left);
         chk($sformatf("vec%0d_right", i), int'(duty_right), vecs[i].right);
         if (i == 0) begin
            chk("run_pid_rst", int'(pif.pid_rst), 0);
            chk("run_state",   int'(state),       1);
            chk("run_lost",    int'(lost),        0);
         end
      end

      // line loss: two held samples, third stops the robot
`ifdef PID_SEQ_SEARCH_EN
      exp_l = 48; exp_r = 0;
`else
      exp_l = 66; exp_r = 62;
`endif
      sensors_raw = 4'b0000;
      watch_quiet("lost1_quiet", 10);
      step(1);
      for (int k = 1; k <= 2; k++) begin
         if (k == 2) begin
            watch_quiet("lost2_quiet", 15);
            step(1);
         end
         chk($sformatf("lost%0d_lost", k),  int'(lost),       1);
         chk($sformatf("lost%0d_state", k), int'(state),      1);
         chk($sformatf("lost%0d_left", k),  int'(duty_left),  exp_l);
         chk($sformatf("lost%0d_right", k), int'(duty_right), exp_r);
`ifdef PID_SEQ_SEARCH_EN
         chk($sformatf("lost%0d_update", k), int'(update), 1);
`else
         chk($sformatf("lost%0d_update", k), int'(update), 0);
`endif
      end
      watch_quiet("lost3_quiet", 15);
      step(1);
      chk("stop_state",   int'(state),       4);
      chk("stop_left",    int'(duty_left),   0);
      chk("stop_right",   int'(duty_right),  0);
      chk("stop_lost",    int'(lost),        1);
      chk("stop_pid_rst", int'(pif.pid_rst), 1);
      chk("stop_update",  int'(update),      0);
      step(1);
      chk("stop_pid_rst_pulse", int'(pif.pid_rst), 0);
      chk("stop_state_hold",    int'(state),       4);

      sensors_raw = 4'b1001;
      pif.pid_output = 13'sd320;
      wait_update(n);
      chk("resume_latency", n, TICK_DIV + PID_LAT);
      chk("resume_left",    int'(duty_left),  74);
      chk("resume_right",   int'(duty_right), 54);
      chk("resume_lost",    int'(lost),       0);

      // enable dropped mid-SETTLE discards the pending update
      step(11);
      chk("settle_state", int'(state), 2);
      step(2);
      enable = 1'b0;
      step(1);
      chk("dis_state",   int'(state),       0);
      chk("dis_left",    int'(duty_left),   0);
      chk("dis_right",   int'(duty_right),  0);
      chk("dis_pid_rst", int'(pif.pid_rst), 1);
      chk("dis_update",  int'(update),      0);
      watch_quiet("dis_quiet", 10);
      enable = 1'b1;
      pif.pid_output = -13'sd320;
      wait_update(n);
      chk("reen_latency", n, FIRST_LAT);
      chk("reen_left",    int'(duty_left),  54);
      chk("reen_right",   int'(duty_right), 74);

      // every sensor pattern: snapshot, lost flag and resulting state
      lc = 0;
      for (int p = 0; p < 16; p++) begin
         sensors_raw = 4'(p);
         step((p == 0) ? 11 : TICK_DIV);
         v = valid_mask[p];
         if (v) begin
            lc = 0;
            exp_state = 2;
         end else begin
            lc = (lc < LOST_LIMIT) ? lc + 1 : lc;
            exp_state = (lc >= LOST_LIMIT) ? 4 : 1;
         end
         chk($sformatf("pat%0d_sensors", p), int'(pif.sensors), p);
         chk($sformatf("pat%0d_lost", p),    int'(lost),        v ? 0 : 1);
         chk($sformatf("pat%0d_state", p),   int'(state),       exp_state);
      end

      // synchronous reset mid-run restores every reset value
      step(3);
      rst = 1'b1;
      step(1);
      chk_reset_values("midrst");
      rst = 1'b0;
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
